// File: rtl/mem_accel_burst.sv
// mem_accel_burst: burst memory accelerator behind a RoCC-style command/response pair.
// FILL and SUM commands are split into doubleword cache requests with up to MAX_OUT in flight.
// Each request owns a tag slot. A nacked request is replayed from its slot's saved address
// before any new word is issued.
// Optional SETSTRIDE command and programmable stride: define MEM_ACCEL_BURST_STRIDE_EN.
module mem_accel_burst #(
  parameter int unsigned MAX_OUT  = 4,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned STRIDE_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [159:0] cmd,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  output logic [73:0]  resp,
  output logic         resp_vld,
  input  logic         resp_rdy,
  output logic         mem_req_vld,
  input  logic         mem_req_rdy,
  output logic [123:0] mem_req,
  input  logic         mem_resp_vld,
  input  logic [252:0] mem_resp
);

  localparam int unsigned SlotW   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [6:0]  FnFill  = 7'd0;
  localparam logic [6:0]  FnSum   = 7'd1;
  localparam logic [6:0]  FnSetLen = 7'd2;
  localparam logic [63:0] AllOnes = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   done_cnt;
  logic [4:0]         rd;
  logic [63:0]        wdata;
  logic [39:0]        base;
  logic               is_sum;
  logic [63:0]        acc;
  logic [63:0]        resp_data;
  logic               resp_irq;
  logic [MAX_OUT-1:0] slot_vld;
  logic [MAX_OUT-1:0] slot_retry;
  logic [39:0]        slot_addr [MAX_OUT];
  logic               req_vld;
  logic               req_new;
  logic [SlotW-1:0]   req_slot;
  logic [39:0]        req_addr;

  // Command fields
  logic [6:0]  cmd_funct;
  logic [4:0]  cmd_rd;
  logic [63:0] cmd_rs1;
  logic [63:0] cmd_rs2;
  assign cmd_funct = cmd[6:0];
  assign cmd_rd    = cmd[24:20];
  assign cmd_rs1   = cmd[95:32];
  assign cmd_rs2   = cmd[159:96];

  // Memory response fields; tags outside the slot range or on free slots are dropped
  logic [9:0]       rsp_tag;
  logic [SlotW-1:0] rsp_slot;
  logic             rsp_hit;
  logic             rsp_nack;
  logic             rsp_ok;
  logic [63:0]      rsp_data;
  assign rsp_tag  = mem_resp[212:203];
  assign rsp_slot = rsp_tag[SlotW-1:0];
  assign rsp_nack = mem_resp[130];
  assign rsp_data = mem_resp[194:131];
  assign rsp_hit  = mem_resp_vld && (rsp_tag < 10'(MAX_OUT)) && slot_vld[rsp_slot];
  assign rsp_ok   = rsp_hit && !rsp_nack;

  logic unused_bits;
  assign unused_bits = ^{cmd[159:136], cmd[31:25], cmd[19:7],
                         mem_resp[252:213], mem_resp[202:195], mem_resp[129:0]};

  logic             req_fire;
  logic [LEN_W-1:0] done_nxt;
  logic [63:0]      acc_nxt;
  logic [39:0]      word_off;
  logic [39:0]      new_addr;
  logic             stride_bad;
  assign req_fire = req_vld && mem_req_rdy;
  assign done_nxt = done_cnt + LEN_W'(1);
  assign acc_nxt  = acc + rsp_data;

`ifdef MEM_ACCEL_BURST_STRIDE_EN
  logic [STRIDE_W-1:0] stride;
  assign word_off   = 40'(issued) * 40'(stride);
  assign stride_bad = (stride[2:0] != 3'b000);
`else
  assign word_off   = 40'({issued, 3'b000});
  assign stride_bad = 1'b0;
`endif
  assign new_addr = base + word_off;

  // Find the lowest slot awaiting replay and the lowest free slot
  logic             retry_any;
  logic             free_any;
  logic [SlotW-1:0] retry_idx;
  logic [SlotW-1:0] free_idx;
  always_comb begin
    retry_any = 1'b0;
    free_any  = 1'b0;
    retry_idx = '0;
    free_idx  = '0;
    for (int i = int'(MAX_OUT) - 1; i >= 0; i--) begin
      if (slot_retry[i]) begin
        retry_any = 1'b1;
        retry_idx = SlotW'(i);
      end
      if (!slot_vld[i]) begin
        free_any = 1'b1;
        free_idx = SlotW'(i);
      end
    end
  end

  // Control FSM, slot bookkeeping and registered request/response state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      len        <= '0;
      issued     <= '0;
      done_cnt   <= '0;
      rd         <= '0;
      wdata      <= '0;
      base       <= '0;
      is_sum     <= 1'b0;
      acc        <= '0;
      resp_data  <= '0;
      resp_irq   <= 1'b0;
      slot_vld   <= '0;
      slot_retry <= '0;
      for (int i = 0; i < int'(MAX_OUT); i++) slot_addr[i] <= '0;
      req_vld    <= 1'b0;
      req_new    <= 1'b0;
      req_slot   <= '0;
      req_addr   <= '0;
`ifdef MEM_ACCEL_BURST_STRIDE_EN
      stride     <= STRIDE_W'(8);
`endif
    end else begin
      if (req_fire) begin
        slot_vld[req_slot]   <= 1'b1;
        slot_retry[req_slot] <= 1'b0;
        slot_addr[req_slot]  <= req_addr;
        if (req_new) issued <= issued + LEN_W'(1);
        req_vld <= 1'b0;
      end
      if (rsp_hit) begin
        if (rsp_nack) begin
          slot_retry[rsp_slot] <= 1'b1;
        end else begin
          slot_vld[rsp_slot] <= 1'b0;
          done_cnt           <= done_nxt;
          if (is_sum) acc <= acc_nxt;
        end
      end

      unique case (state)
        StIdle: begin
          if (cmd_vld) begin
            rd       <= cmd_rd;
            wdata    <= cmd_rs1;
            base     <= cmd_rs2[39:0];
            is_sum   <= (cmd_funct == FnSum);
            issued   <= '0;
            done_cnt <= '0;
            acc      <= '0;
            resp_irq <= 1'b0;
            state    <= StDone;
            case (cmd_funct)
              FnFill, FnSum: begin
                if (stride_bad) begin
                  resp_data <= AllOnes;
                  resp_irq  <= 1'b1;
                end else if (len == '0) begin
                  resp_data <= '0;
                end else begin
                  // Slot 0 is always free here, so the first word goes out next cycle
                  state    <= StRun;
                  req_vld  <= 1'b1;
                  req_new  <= 1'b1;
                  req_slot <= '0;
                  req_addr <= cmd_rs2[39:0];
                end
              end
              FnSetLen: begin
                len       <= cmd_rs1[LEN_W-1:0];
                resp_data <= 64'(len);
              end
`ifdef MEM_ACCEL_BURST_STRIDE_EN
              7'd3: begin
                stride    <= cmd_rs1[STRIDE_W-1:0];
                resp_data <= 64'(stride);
              end
`endif
              default: resp_data <= AllOnes;
            endcase
          end
        end
        StRun: begin
          // Load the next request only once the previous one has been accepted
          if (!req_vld) begin
            if (retry_any) begin
              req_vld  <= 1'b1;
              req_new  <= 1'b0;
              req_slot <= retry_idx;
              req_addr <= slot_addr[retry_idx];
            end else if (free_any && (issued < len)) begin
              req_vld  <= 1'b1;
              req_new  <= 1'b1;
              req_slot <= free_idx;
              req_addr <= new_addr;
            end
          end
          if (rsp_ok && (done_nxt == len)) begin
            state     <= StDone;
            resp_data <= is_sum ? acc_nxt : 64'(len);
          end
        end
        StDone: begin
          if (resp_rdy) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign cmd_rdy     = (state == StIdle);
  assign resp_vld    = (state == StDone);
  assign mem_req_vld = req_vld;
  assign mem_req     = {req_addr, 10'(req_slot), is_sum ? 5'd0 : 5'd1, 3'b011, 1'b0, 1'b1,
                        is_sum ? 64'd0 : wdata};
  assign resp        = {resp_data, rd, req_vld, 2'b00, resp_irq, (state != StIdle)};

endmodule
